// File: rtl/dshot_frame_rx.sv
`timescale 1ns/1ps
// dshot_frame_rx
//   DShot line receiver. It samples the raw line on the system clock,
//   classifies each bit by its high-time, assembles 16-bit frames and checks
//   the 4-bit CRC. On a good frame it publishes the 11-bit throttle and the
//   telemetry bit. It also flags loss of signal so that the downstream stages
//   force the motors to zero.
//
//   Optional build macro: DSHOT_BIDIR_EN
//     Selects bidirectional DShot: the line idles high and is inverted. The
//     CRC is also inverted. The ports are the same in both builds.
//
// Ports:
//   clk          system clock (CLK_HZ)
//   rst_n        asynchronous active-low reset
//   dshot_in     raw asynchronous DShot line
//   frame_valid  one-cycle pulse: a CRC-good frame was latched
//   throttle     last good throttle value, 0..2047 (0 while signal_lost)
//   telem_req    telemetry bit of the last good frame (0 while signal_lost)
//   crc_err      one-cycle pulse: 16 bits received, but the CRC mismatched
//   signal_lost  level: no good frame within LOSS_CYCLES clocks
module dshot_frame_rx #(
  parameter int unsigned CLK_HZ      = 16000000,
  parameter int unsigned BIT_RATE    = 150000,
  parameter int unsigned LOSS_CYCLES = 1600000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dshot_in,
  output logic        frame_valid,
  output logic [10:0] throttle,
  output logic        telem_req,
  output logic        crc_err,
  output logic        signal_lost
);

  localparam int unsigned BIT_PERIOD = CLK_HZ / BIT_RATE;
  localparam int unsigned THRESH     = BIT_PERIOD / 2;
  localparam int unsigned MIN_HIGH   = BIT_PERIOD / 8;
  localparam int unsigned TIMEOUT    = 2 * BIT_PERIOD;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BP_C  = CW'(BIT_PERIOD);
  localparam logic [CW-1:0] TH_C  = CW'(THRESH);
  localparam logic [CW-1:0] MH_C  = CW'(MIN_HIGH);
  localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [23:0] LOSS_LIM = 24'(LOSS_CYCLES - 1);

`ifdef DSHOT_BIDIR_EN
  localparam logic RAW_IDLE = 1'b1;
`else
  localparam logic RAW_IDLE = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_CHECK} state_t;

  state_t        state;
  logic          sync1, sync2, line_prev;
  logic          line_now, rise, fall;
  logic [CW-1:0] high_cnt, low_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   shift;
  logic [15:0]   shift_next;
  logic          crc_ok;
  logic [23:0]   loss_cnt;

  function automatic logic [3:0] calc_crc(input logic [11:0] v);
    logic [11:0] x;
    x = v ^ (v >> 4) ^ (v >> 8);
`ifdef DSHOT_BIDIR_EN
    return ~x[3:0];
`else
    return x[3:0];
`endif
  endfunction

  // The line is inverted after the synchronizer in the bidirectional build.
  // Everything downstream therefore sees an idle-low, active-high line.
`ifdef DSHOT_BIDIR_EN
  assign line_now = ~sync2;
`else
  assign line_now = sync2;
`endif

  assign rise       = line_now & ~line_prev;
  assign fall       = ~line_now & line_prev;
  assign shift_next = {shift[14:0], (high_cnt >= TH_C)};
  assign crc_ok     = (calc_crc(shift[15:4]) == shift[3:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // The synchronizer resets to the idle level. This keeps the
      // bidirectional build from seeing a false edge after reset.
      sync1       <= RAW_IDLE;
      sync2       <= RAW_IDLE;
      line_prev   <= 1'b0;
    end else begin
      sync1       <= dshot_in;
      sync2       <= sync1;
      line_prev   <= line_now;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      throttle    <= '0;
      telem_req   <= 1'b0;
      signal_lost <= 1'b1;
      loss_cnt    <= '0;
    end else begin
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;

      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          if (rise) begin
            state    <= S_HIGH;
            high_cnt <= ONE_C;
          end
        end

        S_HIGH: begin
          if (fall) begin
            if (high_cnt < MH_C) begin
              state   <= S_IDLE;
              bit_cnt <= '0;
            end else begin
              shift <= shift_next;
              // bit_cnt == 15 here means that this is the 16th bit.
              if (bit_cnt == 4'd15) begin
                state   <= S_CHECK;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                state   <= S_LOW;
                low_cnt <= ONE_C;
              end
            end
          end else if (high_cnt >= BP_C) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
          end else begin
            high_cnt <= high_cnt + ONE_C;
          end
        end

        S_LOW: begin
          if (rise) begin
            state    <= S_HIGH;
            high_cnt <= ONE_C;
          end else if (low_cnt >= TO_C) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
          end else begin
            low_cnt <= low_cnt + ONE_C;
          end
        end

        S_CHECK: begin
          frame_valid <= crc_ok;
          crc_err     <= ~crc_ok;
          state       <= S_IDLE;
          bit_cnt     <= '0;
        end

        default: begin
          state   <= S_IDLE;
          bit_cnt <= '0;
        end
      endcase

      // A good frame takes priority over the loss force. This lets the new
      // values and the cleared signal_lost appear in the same cycle.
      if (state == S_CHECK && crc_ok) begin
        throttle    <= shift[15:5];
        telem_req   <= shift[4];
        signal_lost <= 1'b0;
        loss_cnt    <= '0;
      end else begin
        if (loss_cnt != '1) begin
          loss_cnt <= loss_cnt + 24'd1;
        end
        if (loss_cnt >= LOSS_LIM) begin
          signal_lost <= 1'b1;
          throttle    <= '0;
          telem_req   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dshot_frame_rx.sv
`timescale 1ns/1ps
module tb_dshot_frame_rx;

  localparam int unsigned LOSS = 20000;

`ifdef DSHOT_BIDIR_EN
  localparam logic        IDLE_LVL = 1'b1;
  localparam logic [15:0] GOOD_A   = 16'h82C9;  // 1046, telem 0, inverted CRC
  localparam logic [15:0] GOOD_B   = 16'h0618;  // 48, telem 1, inverted CRC
  localparam logic [15:0] BAD_F    = 16'h0617;  // plain CRC is wrong here
`else
  localparam logic        IDLE_LVL = 1'b0;
  localparam logic [15:0] GOOD_A   = 16'h82C6;
  localparam logic [15:0] GOOD_B   = 16'h0617;
  localparam logic [15:0] BAD_F    = 16'h82C7;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dshot_in;
  logic        frame_valid;
  logic [10:0] throttle;
  logic        telem_req;
  logic        crc_err;
  logic        signal_lost;

  always #5 clk = ~clk;

  dshot_frame_rx #(
    .CLK_HZ(16000000),
    .BIT_RATE(150000),
    .LOSS_CYCLES(LOSS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dshot_in(dshot_in),
    .frame_valid(frame_valid),
    .throttle(throttle),
    .telem_req(telem_req),
    .crc_err(crc_err),
    .signal_lost(signal_lost)
  );

  typedef struct {
    logic        is_err;
    logic [10:0] thr;
    logic        tel;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Drives the first n bits of f, MSB first. The T1H is 80 clocks, the T0H
  // is 40 clocks, and the bit period is 106 clocks.
  task automatic send_bits(input logic [15:0] f, input int unsigned n);
    logic b;
    for (int unsigned i = 0; i < n; i++) begin
      b = f[15-i];
      dshot_in = ~IDLE_LVL;
      idle(b ? 80 : 40);
      dshot_in = IDLE_LVL;
      idle(b ? 26 : 66);
    end
  endtask

  task automatic send_frame(input logic [15:0] f, input logic is_err,
                            input logic [10:0] thr, input logic tel);
    exp_t e;
    e.is_err = is_err;
    e.thr    = thr;
    e.tel    = tel;
    sb.push_back(e);
    send_bits(f, 16);
    idle(300);
  endtask

  // The scoreboard monitor checks every strobe against the next queued
  // expectation.
  always @(negedge clk) begin
    if (rst_n && (frame_valid || crc_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, frame_valid, crc_err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_crc_err", {31'd0, crc_err}, {31'd0, mon_e.is_err});
        check("strobe_frame_valid", {31'd0, frame_valid}, {31'd0, ~mon_e.is_err});
        check("strobe_throttle", {21'd0, throttle}, {21'd0, mon_e.thr});
        check("strobe_telem", {31'd0, telem_req}, {31'd0, mon_e.tel});
        if (!mon_e.is_err) check("strobe_signal_lost", {31'd0, signal_lost}, 32'd0);
      end
    end
  end

  initial begin
    dshot_in = IDLE_LVL;
    rst_n    = 1'b0;
    idle(5);
    check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_crc_err", {31'd0, crc_err}, 32'd0);
    check("rst_throttle", {21'd0, throttle}, 32'd0);
    check("rst_telem", {31'd0, telem_req}, 32'd0);
    check("rst_signal_lost", {31'd0, signal_lost}, 32'd1);
    rst_n = 1'b1;

    // Silence after reset: the receiver stays lost with zero outputs.
    idle(LOSS / 2);
    check("silence_mid_lost", {31'd0, signal_lost}, 32'd1);
    idle(LOSS / 2 + 100);
    check("silence_end_lost", {31'd0, signal_lost}, 32'd1);
    check("silence_throttle", {21'd0, throttle}, 32'd0);

    send_frame(GOOD_A, 1'b0, 11'd1046, 1'b0);
    check("good_a_throttle", {21'd0, throttle}, 32'd1046);
    check("good_a_lost", {31'd0, signal_lost}, 32'd0);

    send_frame(BAD_F, 1'b1, 11'd1046, 1'b0);
    check("bad_hold_throttle", {21'd0, throttle}, 32'd1046);

    send_frame(GOOD_B, 1'b0, 11'd48, 1'b1);
    check("good_b_telem", {31'd0, telem_req}, 32'd1);

    // A 9-bit fragment followed by a long low produces no strobe.
    send_bits(GOOD_A, 9);
    idle(250);
    send_frame(GOOD_A, 1'b0, 11'd1046, 1'b0);

    // A 5-clock glitch mid-frame aborts the frame. The remaining 11 bits
    // then time out.
    send_bits(GOOD_B, 5);
    dshot_in = ~IDLE_LVL;
    idle(5);
    dshot_in = IDLE_LVL;
    idle(60);
    send_bits({GOOD_B[10:0], 5'd0}, 11);
    idle(250);
    send_frame(GOOD_B, 1'b0, 11'd48, 1'b1);

    // An asynchronous reset mid-frame discards the partial frame.
    send_bits(GOOD_A, 8);
    rst_n = 1'b0;
    idle(3);
    check("midrst_throttle", {21'd0, throttle}, 32'd0);
    check("midrst_lost", {31'd0, signal_lost}, 32'd1);
    dshot_in = IDLE_LVL;
    rst_n = 1'b1;
    idle(300);
    send_frame(GOOD_A, 1'b0, 11'd1046, 1'b0);
    check("pre_loss_throttle", {21'd0, throttle}, 32'd1046);

    // Silence after good frames forces zero outputs.
    idle(LOSS + 100);
    check("loss_lost", {31'd0, signal_lost}, 32'd1);
    check("loss_throttle", {21'd0, throttle}, 32'd0);
    check("loss_telem", {31'd0, telem_req}, 32'd0);

    idle(50);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
